// File: rtl/wb_icu186_if.sv
// Wishbone slave bus bundle for the 80186 interrupt controller register window.
interface wb_icu186_if;
  logic [3:0]  wb_adr_i;
  logic [15:0] wb_dat_i;
  logic [15:0] wb_dat_o;
  logic [1:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_ack_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
    output wb_dat_o, wb_ack_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
    input  wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_icu186.sv
// 80186-style interrupt control unit: INT0 (Tube IRQ) with mask/in-service/EOI,
// non-maskable NMI, and acknowledge-cycle vector supply for the Zet core.
module wb_icu186 #(
  parameter logic [7:0]  INT0_VECTOR = 8'h0C,
  parameter logic [7:0]  NMI_VECTOR  = 8'h02,
  parameter logic [15:0] INT0CON_RST = 16'h000F
) (
  input  logic        clk,
  input  logic        rst,
  wb_icu186_if.slave  wb,
  input  logic        irq_n_i,
  input  logic        nmi_n_i,
  output logic        intr_o,
  input  logic        inta_i,
  output logic        nmi_o,
  input  logic        nmia_i,
  output logic [15:0] vec_o
);

  localparam logic [3:0] OFF_EOI     = 4'h1;
  localparam logic [3:0] OFF_IMASK   = 4'h4;
  localparam logic [3:0] OFF_INSERV  = 4'h6;
  localparam logic [3:0] OFF_REQST   = 4'h7;
  localparam logic [3:0] OFF_INT0CON = 4'hC;

  logic        ack_q, ack_d;
  logic [15:0] dat_q, dat_d;
  logic [2:0]  irq_s_q, irq_s_d;
  logic [2:0]  nmi_s_q, nmi_s_d;
  logic        inta_q, nmia_q;
  logic        req_q, req_d;
  logic        nmip_q, nmip_d;
  logic        insrv_q, insrv_d;
  logic [4:0]  con_q, con_d;
  logic        intr_q, intr_d;

  logic        bus_req, wr_lo;
  logic        irq_edge, nmi_edge, inta_evt, nmia_evt;
  logic [15:0] rdata;
  logic        unused_ok;

  assign unused_ok = ^{wb.wb_dat_i[14:5], wb.wb_sel_i[1]};

  always_comb begin
    bus_req  = wb.wb_stb_i & wb.wb_cyc_i & ~ack_q;
    wr_lo    = bus_req & wb.wb_we_i & wb.wb_sel_i[0];
    irq_edge = irq_s_q[1] & ~irq_s_q[2];
    nmi_edge = nmi_s_q[1] & ~nmi_s_q[2];
    inta_evt = inta_i & ~inta_q;
    nmia_evt = nmia_i & ~nmia_q;

    // Synchroniser chains carry the active-high (inverted) level.
    irq_s_d = {irq_s_q[1:0], ~irq_n_i};
    nmi_s_d = {nmi_s_q[1:0], ~nmi_n_i};

    rdata = '0;
    unique case (wb.wb_adr_i)
      OFF_IMASK:   rdata[4]   = con_q[3];
      OFF_INSERV:  rdata[4]   = insrv_q;
      OFF_REQST:   rdata      = {nmip_q, 10'd0, req_q, 4'd0};
      OFF_INT0CON: rdata[4:0] = con_q;
      default:     rdata      = '0;
    endcase

    ack_d = bus_req;
    dat_d = (bus_req && !wb.wb_we_i) ? rdata : '0;

    // INT0CON[3] and IMASK[4] are one physical bit.
    con_d = con_q;
    if (wr_lo && wb.wb_adr_i == OFF_INT0CON) con_d = wb.wb_dat_i[4:0];
    if (wr_lo && wb.wb_adr_i == OFF_IMASK)   con_d[3] = wb.wb_dat_i[4];

    insrv_d = insrv_q;
    if (wr_lo && wb.wb_adr_i == OFF_INSERV) insrv_d = wb.wb_dat_i[4];
    if (wr_lo && wb.wb_adr_i == OFF_EOI &&
        (wb.wb_dat_i[15] || wb.wb_dat_i[4:0] == INT0_VECTOR[4:0]))
      insrv_d = 1'b0;
    if (inta_evt) insrv_d = 1'b1;

    if (con_q[4])      req_d = irq_s_q[1];
    else if (irq_edge) req_d = 1'b1;
    else if (inta_evt) req_d = 1'b0;
    else               req_d = req_q;

    if (nmi_edge)      nmip_d = 1'b1;
    else if (nmia_evt) nmip_d = 1'b0;
    else               nmip_d = nmip_q;

    intr_d = req_q & ~con_q[3] & ~insrv_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q   <= 1'b0;
      dat_q   <= '0;
      irq_s_q <= '0;
      nmi_s_q <= '0;
      inta_q  <= 1'b0;
      nmia_q  <= 1'b0;
      req_q   <= 1'b0;
      nmip_q  <= 1'b0;
      insrv_q <= 1'b0;
      con_q   <= INT0CON_RST[4:0];
      intr_q  <= 1'b0;
    end else begin
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      irq_s_q <= irq_s_d;
      nmi_s_q <= nmi_s_d;
      inta_q  <= inta_i;
      nmia_q  <= nmia_i;
      req_q   <= req_d;
      nmip_q  <= nmip_d;
      insrv_q <= insrv_d;
      con_q   <= con_d;
      intr_q  <= intr_d;
    end
  end

  always_comb begin
    if (nmia_i)      vec_o = {8'h00, NMI_VECTOR};
    else if (inta_i) vec_o = {8'h00, INT0_VECTOR};
    else             vec_o = '0;
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign intr_o      = intr_q;
  assign nmi_o       = nmip_q;

endmodule

// File: tb/tb_wb_icu186.sv
// Directed bench for wb_icu186: expected values queued at stimulus, checked on DUT response.
module tb_wb_icu186;
  logic        clk = 1'b0;
  logic        rst;
  logic        irq_n, nmi_n, inta, nmia, intr, nmi;
  logic [15:0] vec;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } sb_t;
  sb_t sb_q[$];

  wb_icu186_if wbif();

  wb_icu186 #(
    .INT0_VECTOR(8'h0C),
    .NMI_VECTOR (8'h02),
    .INT0CON_RST(16'h000F)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .wb     (wbif),
    .irq_n_i(irq_n),
    .nmi_n_i(nmi_n),
    .intr_o (intr),
    .inta_i (inta),
    .nmi_o  (nmi),
    .nmia_i (nmia),
    .vec_o  (vec)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic expect_val(input string tag, input logic [15:0] val);
    sb_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic observe(input logic [15:0] obs);
    sb_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL sb_underflow observed=%h expected=none", obs);
      return;
    end
    e = sb_q.pop_front();
    assert (obs === e.val) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    expect_val(tag, exp);
    observe(obs);
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wb_cycle(input logic [3:0] adr, input logic [15:0] dat, input logic [1:0] sel,
                          input logic we, output int unsigned lat, output logic [15:0] rd);
    if (wbif.wb_ack_o) @(negedge clk);
    wbif.wb_adr_i = adr;
    wbif.wb_dat_i = dat;
    wbif.wb_sel_i = sel;
    wbif.wb_we_i  = we;
    wbif.wb_stb_i = 1'b1;
    wbif.wb_cyc_i = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!wbif.wb_ack_o && lat < 8);
    rd = wbif.wb_dat_o;
    wbif.wb_stb_i = 1'b0;
    wbif.wb_cyc_i = 1'b0;
    wbif.wb_we_i  = 1'b0;
  endtask

  task automatic wb_write(input logic [3:0] adr, input logic [15:0] dat, input logic [1:0] sel);
    int unsigned lat;
    logic [15:0] rd;
    wb_cycle(adr, dat, sel, 1'b1, lat, rd);
    chk("wr_ack_latency", 16'(lat), 16'd1);
  endtask

  task automatic wb_read(input string tag, input logic [3:0] adr, input logic [15:0] exp);
    int unsigned lat;
    logic [15:0] rd;
    expect_val(tag, exp);
    wb_cycle(adr, 16'h0000, 2'b11, 1'b0, lat, rd);
    observe(rd);
    chk("rd_ack_latency", 16'(lat), 16'd1);
  endtask

  // Rising inta: vector present combinationally, intr_o low one edge after the acknowledge edge.
  task automatic do_ack(input string tag);
    inta = 1'b1;
    #1 chk({tag, "_vec"}, vec, 16'h000C);
    @(negedge clk);
    inta = 1'b0;
    #1 chk({tag, "_vec_idle"}, vec, 16'h0000);
    @(negedge clk);
    chk({tag, "_intr_drop"}, 16'(intr), 16'd0);
  endtask

  initial begin
    rst = 1'b1;
    irq_n = 1'b1; nmi_n = 1'b1; inta = 1'b0; nmia = 1'b0;
    wbif.wb_adr_i = '0; wbif.wb_dat_i = '0; wbif.wb_sel_i = '0;
    wbif.wb_we_i = 1'b0; wbif.wb_stb_i = 1'b0; wbif.wb_cyc_i = 1'b0;
    tick(3);
    rst = 1'b0;

    chk("rst_intr", 16'(intr), 16'd0);
    chk("rst_nmi", 16'(nmi), 16'd0);
    chk("rst_ack", 16'(wbif.wb_ack_o), 16'd0);
    chk("rst_dat", wbif.wb_dat_o, 16'h0000);
    chk("rst_vec", vec, 16'h0000);
    wb_read("rst_int0con", 4'hC, 16'h000F);
    wb_read("rst_imask", 4'h4, 16'h0010);
    wb_read("rst_reqst", 4'h7, 16'h0000);
    wb_read("rst_inserv", 4'h6, 16'h0000);
    wb_read("eoi_reads0", 4'h1, 16'h0000);

    // Masked edge: request latched, no intr
    irq_n = 1'b0; tick(2); irq_n = 1'b1; tick(3);
    chk("masked_intr", 16'(intr), 16'd0);
    wb_read("masked_reqst", 4'h7, 16'h0010);

    // Unmask with request pending: intr follows one edge after the write edge
    wb_write(4'hC, 16'h0000, 2'b11);
    chk("unmask_k", 16'(intr), 16'd0);
    tick(1);
    chk("unmask_k1", 16'(intr), 16'd1);
    do_ack("ack1");
    wb_read("ack1_inserv", 4'h6, 16'h0010);
    wb_read("ack1_reqst", 4'h7, 16'h0000);
    wb_write(4'h1, 16'h8000, 2'b11);
    wb_read("nseoi_inserv", 4'h6, 16'h0000);

    // Edge request latency from first low sample
    irq_n = 1'b0; tick(3);
    chk("irq_lat_n2", 16'(intr), 16'd0);
    tick(1);
    chk("irq_lat_n3", 16'(intr), 16'd1);
    irq_n = 1'b1;
    do_ack("ack2");

    // Nested request while in service
    irq_n = 1'b0; tick(2); irq_n = 1'b1; tick(4);
    chk("nested_intr", 16'(intr), 16'd0);
    wb_read("nested_reqst", 4'h7, 16'h0010);
    wb_write(4'h1, 16'h0005, 2'b11);
    wb_read("eoi_nomatch", 4'h6, 16'h0010);
    wb_write(4'h1, 16'h000C, 2'b11);
    chk("spec_eoi_k", 16'(intr), 16'd0);
    tick(1);
    chk("spec_eoi_k1", 16'(intr), 16'd1);
    do_ack("ack3");
    wb_write(4'h1, 16'h8000, 2'b11);

    // Level mode
    wb_write(4'hC, 16'h0010, 2'b11);
    irq_n = 1'b0; tick(4);
    chk("level_intr", 16'(intr), 16'd1);
    do_ack("ack_lvl");
    wb_read("level_req_kept", 4'h7, 16'h0010);
    wb_write(4'h1, 16'h8000, 2'b11);
    chk("level_eoi_k", 16'(intr), 16'd0);
    tick(1);
    chk("level_reassert", 16'(intr), 16'd1);
    irq_n = 1'b1; tick(3);
    wb_read("level_release", 4'h7, 16'h0000);
    chk("level_intr_off", 16'(intr), 16'd0);
    wb_write(4'hC, 16'h0008, 2'b11);

    // NMI
    nmi_n = 1'b0; tick(2);
    chk("nmi_lat_n1", 16'(nmi), 16'd0);
    nmi_n = 1'b1; tick(1);
    chk("nmi_lat_n2", 16'(nmi), 16'd1);
    wb_read("nmi_reqst", 4'h7, 16'h8000);
    chk("nmi_intr_masked", 16'(intr), 16'd0);
    nmia = 1'b1; inta = 1'b1;
    #1 chk("vec_nmi_prio", vec, 16'h0002);
    inta = 1'b0;
    #1 chk("vec_nmi", vec, 16'h0002);
    @(negedge clk);
    chk("nmia_clear", 16'(nmi), 16'd0);
    nmia = 1'b0;
    nmi_n = 1'b0; tick(2);
    nmia = 1'b1; nmi_n = 1'b1; tick(1);
    chk("nmi_collision", 16'(nmi), 16'd1);
    nmia = 1'b0; tick(1);
    nmia = 1'b1; tick(1);
    chk("nmi_clear2", 16'(nmi), 16'd0);
    nmia = 1'b0;

    // Bus byte lanes and IMASK mirror
    wb_write(4'hC, 16'hFFF0, 2'b10);
    wb_read("sel_hi_only", 4'hC, 16'h0008);
    wb_write(4'hC, 16'h0013, 2'b01);
    wb_read("imask_mirror0", 4'h4, 16'h0000);
    wb_write(4'h4, 16'h0010, 2'b01);
    wb_read("imask_to_con", 4'hC, 16'h001B);
    wb_read("unmapped_off3", 4'h3, 16'h0000);

    // Reset during a strobe drops the ack
    wbif.wb_adr_i = 4'hC; wbif.wb_we_i = 1'b0;
    wbif.wb_stb_i = 1'b1; wbif.wb_cyc_i = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_drops_ack", 16'(wbif.wb_ack_o), 16'd0);
    chk("rst_drops_dat", wbif.wb_dat_o, 16'h0000);
    wbif.wb_stb_i = 1'b0; wbif.wb_cyc_i = 1'b0;
    rst = 1'b0;
    wb_read("con_after_rst", 4'hC, 16'h000F);

    chk("sb_drained", 16'(sb_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
